div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage divide request/response bundle.
// The pipeline side is the master; the divider is the slave.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic                 div_start;
   logic                 signed_div;
   logic [WIDTH-1:0]     opdata1;
   logic [WIDTH-1:0]     opdata2;
   logic                 annul;
   logic [2*WIDTH-1:0]   result;
   logic                 ready;
   logic                 stallreq_for_div;

   modport master (
      output div_start, signed_div, opdata1, opdata2, annul,
      input  result, ready, stallreq_for_div
   );

   modport slave (
      input  div_start, signed_div, opdata1, opdata2, annul,
      output result, ready, stallreq_for_div
   );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle; result is {remainder, quotient}.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   div_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_BYZERO = 2'b01,
      S_ON     = 2'b10,
      S_END    = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH:0]   work_q, work_step;
   logic [WIDTH-1:0]   dvsr_q;
   logic               neg_q_q, neg_r_q;
   logic [2*WIDTH-1:0] result_q;
   logic [WIDTH+1:0]   partial;
   logic               ge;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic               start, last, ready;

   assign start = bus.div_start & ~bus.annul;
   assign last  = cnt_q == CW'(WIDTH - 1);

   assign a_mag = (bus.signed_div & bus.opdata1[WIDTH-1]) ?
                  -bus.opdata1 : bus.opdata1;
   assign b_mag = (bus.signed_div & bus.opdata2[WIDTH-1]) ?
                  -bus.opdata2 : bus.opdata2;

   // Partial remainder shifted left with the next dividend bit appended.
   assign partial = {work_q[2*WIDTH:WIDTH], work_q[WIDTH-1]};
   assign ge      = partial >= {2'b00, dvsr_q};

   assign work_step[2*WIDTH:WIDTH] =
      ge ? (WIDTH+1)'(partial - {2'b00, dvsr_q}) : partial[WIDTH:0];
   assign work_step[WIDTH-1:0] = {work_q[WIDTH-2:0], ge};

   assign q_fix = neg_q_q ? -work_step[WIDTH-1:0]
                          : work_step[WIDTH-1:0];
   assign r_fix = neg_r_q ? -work_step[2*WIDTH-1:WIDTH]
                          : work_step[2*WIDTH-1:WIDTH];

   // A flush in the completion cycle hides the pulse from the pipeline.
   assign ready                = (state_q == S_END) & ~bus.annul;
   assign bus.ready            = ready;
   assign bus.stallreq_for_div = bus.div_start & ~ready;
   assign bus.result           = result_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (bus.opdata2 == '0) ? S_BYZERO : S_ON;
         end
         S_BYZERO: state_d = bus.annul ? S_IDLE : S_END;
         S_ON: begin
            if (bus.annul)
               state_d = S_IDLE;
            else if (last)
               state_d = S_END;
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         work_q   <= '0;
         dvsr_q   <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && bus.opdata2 != '0) begin
                  work_q  <= {{(WIDTH+1){1'b0}}, a_mag};
                  dvsr_q  <= b_mag;
                  neg_q_q <= bus.signed_div &
                             (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                  neg_r_q <= bus.signed_div & bus.opdata1[WIDTH-1];
                  cnt_q   <= '0;
               end
            end
            S_BYZERO: begin
               if (!bus.annul)
                  result_q <= '0;
            end
            S_ON: begin
               if (bus.annul) begin
                  cnt_q <= '0;
               end else begin
                  work_q <= work_step;
                  cnt_q  <= cnt_q + CW'(1);
                  if (last) begin
                     cnt_q    <= '0;
                     result_q <= {r_fix, q_fix};
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with a cycle-level
// latency model and per-cycle output comparison.
module tb_div_seq;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   div_seq_if #(.WIDTH(32)) bus ();

   div_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Reference: plain arithmetic, truncating division, low 32 bits kept.
   function automatic logic [63:0] ref_div(input bit s,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint la, lb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
      end else begin
         la = longint'({32'd0, a});
         lb = longint'({32'd0, b});
      end
      q = la / lb;
      r = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Model: a division accepted in cycle n completes L cycles later,
   // L = 2 for a zero divisor and 33 otherwise.
   bit          m_busy, m_done;
   int          m_left;
   logic [63:0] m_pend;
   logic [63:0] m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_res  <= 64'd0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy) begin
         if (bus.annul) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end else begin
            m_left <= m_left - 1;
         end
      end else if (bus.div_start && !bus.annul) begin
         m_busy <= 1'b1;
         m_left <= (bus.opdata2 == 32'd0) ? 1 : 32;
         m_pend <= ref_div(bus.signed_div, bus.opdata1, bus.opdata2);
      end
   end

   always @(negedge clk) begin : cmp
      logic er, es;
      if (chk_en) begin
         er = m_done && !bus.annul;
         es = bus.div_start && !er;
         vectors++;
         if (bus.ready !== er || bus.stallreq_for_div !== es ||
             bus.result !== m_res) begin
            miscompares++;
            $display("FAIL cycle t=%0t ready=%b want %b stall=%b want %b result=%h want %h",
                     $time, bus.ready, er, bus.stallreq_for_div, es,
                     bus.result, m_res);
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h want %h", nm, got, exp);
      end
   endtask

   // Entered just after a rising edge; that cycle is the start cycle.
   task automatic do_div(input string nm, input bit s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat,
                         input bit hold);
      int lat;
      lat = -1;
      bus.signed_div = s;
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.div_start  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #1;
         bus.opdata1    = $urandom;
         bus.opdata2    = $urandom;
         bus.signed_div = 1'($urandom_range(0, 1));
      end
      check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
      check({nm, "_res"}, bus.result, exp);
      @(posedge clk);
      #1;
      if (!hold) bus.div_start = 1'b0;
   endtask

   initial begin : stim
      int rdy_seen;
      rst            = 1'b1;
      bus.div_start  = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      bus.annul      = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_result", bus.result, 64'd0);
      check("rst_ready", 64'(bus.ready), 64'd0);
      check("rst_stall", 64'(bus.stallreq_for_div), 64'd0);

      // A request seen only during reset must not start anything.
      @(posedge clk);
      #1;
      bus.div_start = 1'b1;
      bus.opdata1   = 32'd5;
      bus.opdata2   = 32'd1;
      @(posedge clk);
      #1;
      bus.div_start = 1'b0;
      rst           = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      do_div("u100_7", 1'b0, 32'd100, 32'd7,
             {32'd2, 32'h0000000E}, 33, 1'b0);
      do_div("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
             {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
      do_div("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
             {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0);
      do_div("byzero", 1'b0, 32'h1234, 32'd0, 64'd0, 2, 1'b0);
      do_div("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
             {32'h0, 32'h80000000}, 33, 1'b0);
      do_div("u_big", 1'b0, 32'hFFFFFFF9, 32'd2,
             {32'h1, 32'h7FFFFFFC}, 33, 1'b0);
      do_div("sm100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
             {32'hFFFFFFFE, 32'h0000000E}, 33, 1'b0);

      // Flush in cycle 10 of ON.
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd1000;
      bus.opdata2    = 32'd3;
      bus.div_start  = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.annul = 1'b1;
      @(posedge clk);
      #1;
      bus.annul     = 1'b0;
      bus.div_start = 1'b0;
      rdy_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready) rdy_seen++;
      end
      check("annul_ready", 64'(rdy_seen), 64'd0);
      check("annul_res", bus.result, {32'hFFFFFFFE, 32'h0000000E});

      // Reset in cycle 20 of a new division.
      @(posedge clk);
      #1;
      bus.opdata1   = 32'd50;
      bus.opdata2   = 32'd5;
      bus.div_start = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rst           = 1'b1;
      bus.div_start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_res", bus.result, 64'd0);
      check("midrst_ready", 64'(bus.ready), 64'd0);
      @(posedge clk);
      #1;

      // Back-to-back: request held into the IDLE cycle after END.
      do_div("b2b_1", 1'b0, 32'd100, 32'd7,
             {32'd2, 32'h0000000E}, 33, 1'b1);
      do_div("b2b_2", 1'b0, 32'd9, 32'd3,
             {32'd0, 32'd3}, 33, 1'b0);
      do_div("u_f_16", 1'b0, 32'hFFFFFFFF, 32'h10,
             {32'hF, 32'h0FFFFFFF}, 33, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
